// File: rtl/i2c_bit_sequencer.sv
// i2c_bit_sequencer: I2C bit-level sequencer (START/STOP/WRITE/READ) with prescaled quarter phases.
// Ports:
//   clk_i, rst_n             clock, asynchronous active-low reset
//   clk_div                  quarter-phase length minus one, latched on command accept
//   cmd_valid/cmd_ready      command handshake; cmd (00 START, 01 STOP, 10 WRITE, 11 READ), cmd_bit
//   done, arb_lost           single-cycle completion / arbitration-loss pulses
//   rd_bit                   bit captured by the last READ
//   busy                     bus ownership between a completed START and STOP
//   scl_o, sda_o             open-drain drives (1 = release)
//   scl_i, sda_i             line readback for clock stretching, read data and arbitration
module i2c_bit_sequencer #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic             cmd_bit,
    output logic             done,
    output logic             rd_bit,
    output logic             arb_lost,
    output logic             busy,
    output logic             scl_o,
    output logic             sda_o,
    input  logic             scl_i,
    input  logic             sda_i
);
    localparam logic [1:0] START = 2'b00;
    localparam logic [1:0] STOP  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] READ  = 2'b11;

    typedef enum logic [2:0] {IDLE, PA, PB, PC, PD} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, div_q;
    logic [1:0]       cmd_q, cur_cmd;
    logic             bit_q, cur_bit;
    logic             accept, frozen, tick, arb_hit, done_nxt;
    logic             scl_nxt, sda_nxt, busy_nxt, rd_nxt;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // A slave holding SCL low in PB stretches the high phase by freezing the prescaler.
    assign frozen    = (state == PB) && !scl_i;
    assign tick      = (state != IDLE) && !frozen && (cnt == div_q);
    // Only levels we released can be lost: START's SDA high and a WRITE of 1.
    assign arb_hit   = (state == PB) && tick && !sda_i &&
                       ((cmd_q == START) || ((cmd_q == WRITE) && bit_q));
    assign done_nxt  = (state == PD) && tick;
    // On the accept cycle the latched command is not yet valid, so use the live inputs.
    assign cur_cmd   = accept ? cmd : cmd_q;
    assign cur_bit   = accept ? cmd_bit : bit_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= '0;
            cmd_q    <= START;
            bit_q    <= 1'b0;
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
            done     <= 1'b0;
            arb_lost <= 1'b0;
            busy     <= 1'b0;
            rd_bit   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == IDLE || tick) ? '0 : frozen ? cnt : cnt + 1'b1;
            div_q    <= accept ? clk_div : div_q;
            cmd_q    <= accept ? cmd : cmd_q;
            bit_q    <= accept ? cmd_bit : bit_q;
            scl_o    <= scl_nxt;
            sda_o    <= sda_nxt;
            done     <= done_nxt;
            arb_lost <= arb_hit;
            busy     <= busy_nxt;
            rd_bit   <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? PA : IDLE;
            PA:      state_nxt = tick ? PB : PA;
            PB:      state_nxt = arb_hit ? IDLE : tick ? PC : PB;
            PC:      state_nxt = tick ? PD : PC;
            PD:      state_nxt = tick ? IDLE : PD;
            default: state_nxt = IDLE;
        endcase
    end

    // Line levels are loaded on phase entry and otherwise held, so IDLE keeps the last levels.
    always_comb begin
        scl_nxt  = scl_o;
        sda_nxt  = sda_o;
        if (arb_hit) begin
            scl_nxt = 1'b1;
            sda_nxt = 1'b1;
        end else if (state_nxt != state) begin
            case (state_nxt)
                PA: begin
                    scl_nxt = (cur_cmd == START) ? scl_o : 1'b0;
                    sda_nxt = (cur_cmd == STOP) ? 1'b0 : (cur_cmd == WRITE) ? cur_bit : 1'b1;
                end
                PB: begin
                    scl_nxt = 1'b1;
                    sda_nxt = (cur_cmd == STOP) ? 1'b0 : (cur_cmd == WRITE) ? cur_bit : 1'b1;
                end
                PC: begin
                    scl_nxt = 1'b1;
                    sda_nxt = (cur_cmd == START) ? 1'b0 : (cur_cmd == WRITE) ? cur_bit : 1'b1;
                end
                PD: begin
                    scl_nxt = (cur_cmd == STOP);
                    sda_nxt = (cur_cmd == START) ? 1'b0 : (cur_cmd == WRITE) ? cur_bit : 1'b1;
                end
                default: begin
                    scl_nxt = scl_o;
                    sda_nxt = sda_o;
                end
            endcase
        end
        busy_nxt = arb_hit ? 1'b0 :
                   (done_nxt && cmd_q == START) ? 1'b1 :
                   (done_nxt && cmd_q == STOP) ? 1'b0 : busy;
        rd_nxt   = (state == PB && tick && cmd_q == READ) ? sda_i : rd_bit;
    end
endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb_i2c_bit_sequencer: self-checking bench for i2c_bit_sequencer.
module tb_i2c_bit_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] clk_div = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = '0;
    logic       cmd_bit = 1'b0;
    logic       done, rd_bit, arb_lost, busy, scl_o, sda_o;
    logic       scl_i = 1'b1;
    logic       sda_i = 1'b1;

    int errors = 0;
    int checks = 0;

    logic m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0, m_rd = 1'b0;
    int   obs_done, obs_arb;

    i2c_bit_sequencer #(.DIV_W(8)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .clk_div(clk_div), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd(cmd), .cmd_bit(cmd_bit), .done(done), .rd_bit(rd_bit),
        .arb_lost(arb_lost), .busy(busy), .scl_o(scl_o), .sda_o(sda_o),
        .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Bus levels (scl,sda) for each command and quarter phase 0..3.
    function automatic logic [1:0] lines(input logic [1:0] c, input logic b, input int ph, input logic prev_scl);
        case (c)
            2'b00:   return (ph == 0) ? {prev_scl, 1'b1} : (ph == 1) ? 2'b11 : (ph == 2) ? 2'b10 : 2'b00;
            2'b01:   return (ph == 0) ? 2'b00 : (ph == 1) ? 2'b10 : 2'b11;
            2'b10:   return {(ph == 1 || ph == 2), b};
            default: return {(ph == 1 || ph == 2), 1'b1};
        endcase
    endfunction

    // Runs one command from cycle 0 (current cycle) until its done/arb cycle, checking every cycle.
    task automatic run_cmd(input logic [1:0] c, input logic b, input int d, input logic sdai,
                           input int s, input bit scramble);
        int   l, a_end, b_end, c_end, d_end, last, ph;
        bit   arb;
        logic [1:0] el;
        logic eb;
        l     = d + 1;
        a_end = l;
        b_end = 2 * l + s;
        c_end = b_end + l;
        d_end = c_end + l;
        arb   = !sdai && (c == 2'b00 || (c == 2'b10 && b));
        last  = arb ? b_end + 1 : d_end + 1;
        obs_done = 0;
        obs_arb  = 0;
        chk("ready_at_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd = c;
        cmd_bit = b;
        clk_div = 8'(d);
        sda_i = sdai;
        scl_i = 1'b1;
        tick();
        for (int t = 1; t <= last; t++) begin
            scl_i = !(t > a_end && t <= a_end + s);
            cmd_valid = (t < last && scramble) ? 1'($urandom) : 1'b0;
            if (scramble) begin
                cmd = 2'($urandom);
                cmd_bit = 1'($urandom);
                clk_div = 8'($urandom);
            end
            if (done && obs_done == 0) obs_done = t;
            if (arb_lost && obs_arb == 0) obs_arb = t;
            ph = (t <= a_end) ? 0 : (t <= b_end) ? 1 : (t <= c_end) ? 2 : 3;
            el = (arb && t == last) ? 2'b11 : lines(c, b, ph, m_scl);
            eb = (arb && t == last) ? 1'b0 :
                 (t == last && c == 2'b00) ? 1'b1 :
                 (t == last && c == 2'b01) ? 1'b0 : m_busy;
            chk("scl_o", scl_o, el[1]);
            chk("sda_o", sda_o, el[0]);
            chk("done", done, !arb && t == last);
            chk("arb_lost", arb_lost, arb && t == last);
            chk("busy", busy, eb);
            chk("cmd_ready", cmd_ready, t == last);
            if (t == last && !arb) chk("rd_bit", rd_bit, (c == 2'b11) ? sdai : m_rd);
            if (t < last) tick();
        end
        if (!arb && c == 2'b11) m_rd = sdai;
        m_busy = eb;
        m_scl = el[1];
        m_sda = el[0];
        scl_i = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) begin
            tick();
            chk("idle_scl", scl_o, m_scl);
            chk("idle_sda", sda_o, m_sda);
            chk("idle_done", done, 0);
            chk("idle_ready", cmd_ready, 1);
        end
    endtask

    typedef struct {
        logic [1:0] c;
        logic       b;
        int         d;
        logic       sdai;
        int         s;
        int         e_done;
        int         e_arb;
        logic       e_busy;
        logic       e_scl;
        logic       e_sda;
        logic       e_rd;
    } vec_t;

    vec_t vec [8];

    initial begin
        vec[0] = '{2'b00, 1'b0, 1, 1'b1, 0,  9, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[1] = '{2'b10, 1'b1, 1, 1'b0, 0,  0, 5, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[2] = '{2'b00, 1'b0, 0, 1'b1, 0,  5, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[3] = '{2'b11, 1'b0, 1, 1'b0, 10, 19, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[4] = '{2'b11, 1'b0, 0, 1'b1, 0,  5, 0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[5] = '{2'b01, 1'b0, 2, 1'b1, 0, 13, 0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[6] = '{2'b00, 1'b0, 1, 1'b0, 0,  0, 5, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[7] = '{2'b10, 1'b0, 3, 1'b0, 0, 17, 0, 1'b0, 1'b0, 1'b0, 1'b1};

        #7;
        chk("rst_scl", scl_o, 1);
        chk("rst_sda", sda_o, 1);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rd", rd_bit, 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        tick();

        foreach (vec[i]) begin
            run_cmd(vec[i].c, vec[i].b, vec[i].d, vec[i].sdai, vec[i].s, 1'b0);
            chk($sformatf("vec%0d_done_cyc", i), obs_done, vec[i].e_done);
            chk($sformatf("vec%0d_arb_cyc", i), obs_arb, vec[i].e_arb);
            chk($sformatf("vec%0d_busy", i), busy, vec[i].e_busy);
            chk($sformatf("vec%0d_scl", i), scl_o, vec[i].e_scl);
            chk($sformatf("vec%0d_sda", i), sda_o, vec[i].e_sda);
            chk($sformatf("vec%0d_rd", i), rd_bit, vec[i].e_rd);
            idle_cycles(1);
        end

        // Reset in the middle of a WRITE while the bus is owned.
        run_cmd(2'b00, 1'b0, 0, 1'b1, 0, 1'b0);
        run_cmd(2'b10, 1'b0, 3, 1'b1, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd = 2'b10;
        cmd_bit = 1'b0;
        clk_div = 8'd3;
        tick();
        cmd_valid = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_scl", scl_o, 1);
        chk("midrst_sda", sda_o, 1);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        @(negedge clk_i);
        rst_n = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        m_busy = 1'b0;
        m_rd = 1'b0;
        tick();
        idle_cycles(2);

        // Back-to-back WRITE 1 then WRITE 0 with cmd_valid held.
        cmd_valid = 1'b1;
        cmd = 2'b10;
        cmd_bit = 1'b1;
        clk_div = 8'd0;
        sda_i = 1'b1;
        tick();
        for (int t = 1; t <= 10; t++) begin
            if (t == 1) cmd_bit = 1'b0;
            if (t == 6) cmd_valid = 1'b0;
            chk($sformatf("b2b_done_c%0d", t), done, t == 5 || t == 10);
            if (t != 5 && t != 10) chk($sformatf("b2b_sda_c%0d", t), sda_o, t < 5);
            if (t < 10) tick();
        end
        m_scl = 1'b0;
        m_sda = 1'b0;

        for (int n = 0; n < 60; n++) begin
            logic [1:0] c;
            logic       b, sdai;
            int         d, s;
            c = 2'($urandom);
            b = 1'($urandom);
            d = $urandom_range(0, 3);
            sdai = ($urandom % 4) != 0;
            s = ($urandom % 3 == 0) ? $urandom_range(1, 5) : 0;
            run_cmd(c, b, d, sdai, s, 1'b1);
            idle_cycles($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
